// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings and receiver FSM states.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE,
        ST_BRKWAIT
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: flags the bit centre (mid) and the bit end (wrap point).
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 10416
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic mid_tick_c,
    output logic bit_tick_c
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign mid_tick_c = (cnt_q == CW'((CLKS_PER_BIT - 1) / 2));
    assign bit_tick_c = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || bit_tick_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with parity/framing/overrun/break detection
// and a valid/ready hold register towards the consumer.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Rx_Serial,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Rx_Valid,
    input  logic                 i_Rx_Ready,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Overrun,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int unsigned IW = $clog2(DATA_BITS + 1);

    uart_state_e state_q, state_d;

    logic                 rx_meta_q, rx_s_q;
    logic                 restart_c, mid_tick_c, bit_tick_c;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ones_q, ones_d;
    logic                 stop2_q, stop2_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 ovr_q, ovr_d;
    logic                 brk_q, brk_d;
    logic                 busy_q, busy_d;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk       (i_Clock),
        .rst_n     (i_Rst_n),
        .restart   (restart_c),
        .mid_tick_c(mid_tick_c),
        .bit_tick_c(bit_tick_c)
    );

    // Two-flop synchroniser, idle-high on reset.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_Rx_Serial;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ones_d     = ones_q;
        stop2_d    = stop2_q;
        restart_c  = 1'b0;
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        ovr_d      = 1'b0;
        brk_d      = 1'b0;

        // Consumer acceptance; a commit below may reload in the same cycle.
        if (valid_q && i_Rx_Ready) begin
            valid_d    = 1'b0;
            perr_out_d = 1'b0;
            ferr_out_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                restart_c = 1'b1;
                idx_d     = '0;
                par_d     = 1'b0;
                perr_d    = 1'b0;
                ferr_d    = 1'b0;
                ones_d    = 1'b0;
                stop2_d   = 1'b0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (mid_tick_c) begin
                    restart_c = 1'b1;
                    state_d   = rx_s_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick_c) begin
                    shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ rx_s_q;
                    ones_d  = ones_q | rx_s_q;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick_c) begin
                    ones_d  = ones_q | rx_s_q;
                    perr_d  = (PARITY == PAR_ODD) ? ~(par_q ^ rx_s_q) : (par_q ^ rx_s_q);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick_c) begin
                    ones_d = ones_q | rx_s_q;
                    if (!rx_s_q) begin
                        ferr_d = 1'b1;
                    end
                    if ((STOP_BITS == 2) && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                restart_c = 1'b1;
                if (!ones_q) begin
                    brk_d   = 1'b1;
                    state_d = ST_BRKWAIT;
                end else begin
                    if (!valid_q || i_Rx_Ready) begin
                        data_d     = shreg_q;
                        perr_out_d = perr_q;
                        ferr_out_d = ferr_q;
                        valid_d    = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_BRKWAIT: begin
                restart_c = 1'b1;
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ones_q     <= 1'b0;
            stop2_q    <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
            brk_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ones_q     <= ones_d;
            stop2_q    <= stop2_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            ovr_q      <= ovr_d;
            brk_q      <= brk_d;
            busy_q     <= busy_d;
        end
    end

    assign o_Rx_Data    = data_q;
    assign o_Rx_Valid   = valid_q;
    assign o_Parity_Err = perr_out_q;
    assign o_Frame_Err  = ferr_out_q;
    assign o_Overrun    = ovr_q;
    assign o_Break      = brk_q;
    assign o_Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three receivers (8N1, 7E1, 8N2) share one
// serial driver gated by a select, each word is checked on acceptance.
module tb_uart_rx_cfg;

    localparam int unsigned CPB = 8;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx    = 1'b1;
    logic [1:0] sel   = 2'd0;
    logic       rdy0  = 1'b1;
    logic       rdy1  = 1'b1;
    logic       rdy2  = 1'b1;

    logic       rx0, rx1, rx2;
    logic [7:0] d0, d2;
    logic [6:0] d1;
    logic       v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2;
    logic       ov0, ov1, ov2, br0, br1, br2, bz0, bz1, bz2;

    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;
    int   n_total = 0;
    int   n_bad   = 0;
    int   n_ov0   = 0;
    int   n_br0   = 0;

    assign rx0 = (sel == 2'd0) ? tx : 1'b1;
    assign rx1 = (sel == 2'd1) ? tx : 1'b1;
    assign rx2 = (sel == 2'd2) ? tx : 1'b1;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx0), .o_Rx_Data(d0), .o_Rx_Valid(v0),
        .i_Rx_Ready(rdy0), .o_Parity_Err(pe0), .o_Frame_Err(fe0), .o_Overrun(ov0),
        .o_Break(br0), .o_Busy(bz0));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_e1 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx1), .o_Rx_Data(d1), .o_Rx_Valid(v1),
        .i_Rx_Ready(rdy1), .o_Parity_Err(pe1), .o_Frame_Err(fe1), .o_Overrun(ov1),
        .o_Break(br1), .o_Busy(bz1));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx2), .o_Rx_Data(d2), .o_Rx_Valid(v2),
        .i_Rx_Ready(rdy2), .o_Parity_Err(pe2), .o_Frame_Err(fe2), .o_Overrun(ov2),
        .o_Break(br2), .o_Busy(bz2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serial frame driver; parity computed here, flip forces a wrong parity bit.
    task automatic send(input logic [8:0] d, input int nb, input int par, input bit flip,
                        input int nstop, input bit last_stop);
        logic p;
        p  = 1'b0;
        tx = 1'b0;
        tick(CPB);
        for (int i = 0; i < nb; i++) begin
            tx = d[i];
            p  = p ^ d[i];
            tick(CPB);
        end
        if (par != 0) begin
            tx = ((par == 2) ? ~p : p) ^ flip;
            tick(CPB);
        end
        for (int i = 0; i < nstop; i++) begin
            tx = (i == nstop - 1) ? last_stop : 1'b1;
            tick(CPB);
        end
        tx = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(v0), 32'h0);
        chk({tag, "_data"},  32'(d0), 32'h0);
        chk({tag, "_busy"},  32'(bz0), 32'h0);
        chk({tag, "_flags"}, 32'({pe0, fe0, ov0, br0}), 32'h0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ov0) n_ov0++;
            if (br0) n_br0++;
            if (v0 && rdy0) begin
                if (q0.size() == 0) chk("n1_unexpected_word", 32'(d0), 32'hFFFF_FFFF);
                else begin
                    e0 = q0.pop_front();
                    chk("n1_data", 32'(d0), 32'(e0.data));
                    chk("n1_perr", 32'(pe0), 32'(e0.perr));
                    chk("n1_ferr", 32'(fe0), 32'(e0.ferr));
                end
            end
            if (v1 && rdy1) begin
                if (q1.size() == 0) chk("e1_unexpected_word", 32'(d1), 32'hFFFF_FFFF);
                else begin
                    e1 = q1.pop_front();
                    chk("e1_data", 32'(d1), 32'(e1.data));
                    chk("e1_perr", 32'(pe1), 32'(e1.perr));
                    chk("e1_ferr", 32'(fe1), 32'(e1.ferr));
                end
            end
            if (v2 && rdy2) begin
                if (q2.size() == 0) chk("n2_unexpected_word", 32'(d2), 32'hFFFF_FFFF);
                else begin
                    e2 = q2.pop_front();
                    chk("n2_data", 32'(d2), 32'(e2.data));
                    chk("n2_perr", 32'(pe2), 32'(e2.perr));
                    chk("n2_ferr", 32'(fe2), 32'(e2.ferr));
                end
            end
        end
    end

    initial begin
        tick(3);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        tick(4);

        // 8N1 clean word with ready held high
        sel = 2'd0;
        q0.push_back('{9'h0A5, 1'b0, 1'b0});
        send(9'h0A5, 8, 0, 1'b0, 1, 1'b1);
        tick(2 * CPB);

        // 7E1 good parity, then flipped parity
        sel = 2'd1;
        q1.push_back('{9'h041, 1'b0, 1'b0});
        send(9'h041, 7, 1, 1'b0, 1, 1'b1);
        tick(2 * CPB);
        q1.push_back('{9'h041, 1'b1, 1'b0});
        send(9'h041, 7, 1, 1'b1, 1, 1'b1);
        tick(2 * CPB);

        // 8N2 with second stop bit low, then a clean frame
        sel = 2'd2;
        q2.push_back('{9'h03C, 1'b0, 1'b1});
        send(9'h03C, 8, 0, 1'b0, 2, 1'b0);
        tick(2 * CPB);
        q2.push_back('{9'h03D, 1'b0, 1'b0});
        send(9'h03D, 8, 0, 1'b0, 2, 1'b1);
        tick(2 * CPB);

        // Overrun: consumer stalled across two frames
        sel  = 2'd0;
        rdy0 = 1'b0;
        q0.push_back('{9'h011, 1'b0, 1'b0});
        send(9'h011, 8, 0, 1'b0, 1, 1'b1);
        tick(2 * CPB);
        send(9'h022, 8, 0, 1'b0, 1, 1'b1);
        tick(2 * CPB);
        chk("ovr_pulses", 32'(n_ov0), 32'd1);
        chk("ovr_hold_data", 32'(d0), 32'h11);
        chk("ovr_hold_valid", 32'(v0), 32'h1);
        rdy0 = 1'b1;
        tick(4);
        chk("ovr_drained_valid", 32'(v0), 32'h0);

        // Break: line low for three frame times
        tx = 1'b0;
        tick(25 * CPB);
        chk("brk_busy_low", 32'(bz0), 32'h1);
        tick(5 * CPB);
        tx = 1'b1;
        tick(6);
        chk("brk_pulses", 32'(n_br0), 32'd1);
        chk("brk_busy_idle", 32'(bz0), 32'h0);
        chk("brk_no_overrun", 32'(n_ov0), 32'd1);
        q0.push_back('{9'h055, 1'b0, 1'b0});
        send(9'h055, 8, 0, 1'b0, 1, 1'b1);
        tick(2 * CPB);

        // Short glitch is rejected, then reset lands mid-frame
        tx = 1'b0;
        tick(3);
        tx = 1'b1;
        tick(2 * CPB);
        chk("glitch_idle", 32'(bz0), 32'h0);
        tx = 1'b0;
        tick(4 * CPB);
        chk("midframe_busy", 32'(bz0), 32'h1);
        rst_n = 1'b0;
        tx    = 1'b1;
        tick(2);
        chk_reset_outputs("midrst");
        rst_n = 1'b1;
        tick(2 * CPB);
        q0.push_back('{9'h099, 1'b0, 1'b0});
        send(9'h099, 8, 0, 1'b0, 1, 1'b1);
        tick(2 * CPB);

        chk("n1_pending", 32'(q0.size()), 32'd0);
        chk("e1_pending", 32'(q1.size()), 32'd0);
        chk("n2_pending", 32'(q2.size()), 32'd0);
        chk("brk_total", 32'(n_br0), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
